lap_stopwatch: RTL and testbench

Parametrised single-clock stopwatch with BCD digit cascade, start/pause/clear control, and a lap-capture FIFO. Sits beside the clock/alarm blocks behind the mode selector. The board's button debouncer drives its single-cycle pulses, and it feeds the 7-segment display mux. All timing is derived from CLK through an internal prescaler; there is no second clock domain.

---
 rtl/lap_stopwatch_if.sv | 33 +++
 rtl/lap_stopwatch.sv | 186 ++++++++++++++++++
 tb/tb_lap_stopwatch.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lap_stopwatch_if.sv
// Control and status bundle between the mode selector / display side and lap_stopwatch.
interface lap_stopwatch_if #(
    parameter int unsigned SEC_DIGITS = 2,
    parameter int unsigned LAP_DEPTH  = 4
);
    localparam int unsigned NDIG = SEC_DIGITS + 2;
    localparam int unsigned TW   = 4 * NDIG;
    localparam int unsigned CW   = $clog2(LAP_DEPTH + 1);

    logic          ENABLE;
    logic          START_STOP;
    logic          CLEAR;
    logic          LAP;
    logic          LAP_RD;
    logic [TW-1:0] TIME;
    logic          RUNNING;
    logic          DONE;
    logic          WRAP;
    logic [TW-1:0] LAP_DATA;
    logic          LAP_VALID;
    logic [CW-1:0] LAP_COUNT;
    logic          LAP_OVF;

    modport master (
        output ENABLE, START_STOP, CLEAR, LAP, LAP_RD,
        input  TIME, RUNNING, DONE, WRAP, LAP_DATA, LAP_VALID, LAP_COUNT, LAP_OVF
    );

    modport slave (
        input  ENABLE, START_STOP, CLEAR, LAP, LAP_RD,
        output TIME, RUNNING, DONE, WRAP, LAP_DATA, LAP_VALID, LAP_COUNT, LAP_OVF
    );
endinterface

// File: rtl/lap_stopwatch.sv
// BCD stopwatch with start/pause/clear control and a lap-capture FIFO.
// Build option: define STOPWATCH_WRAP_EN to roll over at max instead of saturating in DONE.
module lap_stopwatch #(
    parameter int unsigned TICK_DIV   = 500000,
    parameter int unsigned SEC_DIGITS = 2,
    parameter int unsigned LAP_DEPTH  = 4
) (
    input  logic           CLK,
    input  logic           RESET,
    lap_stopwatch_if.slave bus
);
    localparam int unsigned NDIG = SEC_DIGITS + 2;
    localparam int unsigned TW   = 4 * NDIG;
    localparam int unsigned PW   = $clog2(TICK_DIV);
    localparam int unsigned AW   = $clog2(LAP_DEPTH);
    localparam int unsigned CW   = $clog2(LAP_DEPTH + 1);
    localparam logic [TW-1:0] TIME_MAX = {NDIG{4'h9}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        state_q;
    logic [PW-1:0] presc_q;
    logic [TW-1:0] time_q;
    logic          running_q;
    logic          done_q;
    logic [TW-1:0] lap_mem [LAP_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] lap_cnt_q;
    logic [TW-1:0] lap_data_q;
    logic          lap_valid_q;
    logic          lap_ovf_q;
`ifdef STOPWATCH_WRAP_EN
    logic          wrap_q;
`endif

    logic clr_c;
    logic tick_c;
    logic full_c;
    logic lap_c;
    logic pop_c;
    logic push_c;

    // Ripple-carry BCD increment: each digit rolls 9 -> 0 and carries upward.
    function automatic logic [TW-1:0] bcd_inc(input logic [TW-1:0] t);
        logic [TW-1:0] r;
        logic          carry;
        r     = t;
        carry = 1'b1;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (carry) begin
                if (t[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = t[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    always_comb begin
        clr_c  = !bus.ENABLE || bus.CLEAR;
        tick_c = (state_q == ST_RUN) && (presc_q == PW'(TICK_DIV - 1));
        full_c = (lap_cnt_q == CW'(LAP_DEPTH));
        lap_c  = !clr_c && bus.LAP && (state_q == ST_RUN);
        pop_c  = !clr_c && bus.LAP_RD && (lap_cnt_q != '0);
        push_c = lap_c && (!full_c || pop_c);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            time_q      <= '0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            lap_cnt_q   <= '0;
            lap_data_q  <= '0;
            lap_valid_q <= 1'b0;
            lap_ovf_q   <= 1'b0;
            for (int i = 0; i < int'(LAP_DEPTH); i++) lap_mem[i] <= '0;
`ifdef STOPWATCH_WRAP_EN
            wrap_q      <= 1'b0;
`endif
        end else begin
            lap_valid_q <= 1'b0;
`ifdef STOPWATCH_WRAP_EN
            wrap_q      <= 1'b0;
`endif
            if (clr_c) begin
                state_q    <= ST_IDLE;
                presc_q    <= '0;
                time_q     <= '0;
                running_q  <= 1'b0;
                done_q     <= 1'b0;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                lap_cnt_q  <= '0;
                lap_data_q <= '0;
                lap_ovf_q  <= 1'b0;
                for (int i = 0; i < int'(LAP_DEPTH); i++) lap_mem[i] <= '0;
            end else begin
                // START_STOP outranks the tick; a paused prescaler keeps its partial count.
                case (state_q)
                    ST_IDLE: begin
                        if (bus.START_STOP) begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (bus.START_STOP) begin
                            state_q   <= ST_PAUSE;
                            running_q <= 1'b0;
                        end else if (tick_c) begin
                            presc_q <= '0;
                            if (time_q == TIME_MAX) begin
`ifdef STOPWATCH_WRAP_EN
                                time_q <= '0;
                                wrap_q <= 1'b1;
`else
                                state_q   <= ST_DONE;
                                running_q <= 1'b0;
                                done_q    <= 1'b1;
`endif
                            end else begin
                                time_q <= bcd_inc(time_q);
                            end
                        end else begin
                            presc_q <= presc_q + PW'(1);
                        end
                    end
                    ST_PAUSE: begin
                        if (bus.START_STOP) begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase

                if (pop_c) begin
                    lap_data_q  <= lap_mem[rd_ptr_q];
                    lap_valid_q <= 1'b1;
                    rd_ptr_q    <= rd_ptr_q + AW'(1);
                end
                if (push_c) begin
                    lap_mem[wr_ptr_q] <= time_q;
                    wr_ptr_q          <= wr_ptr_q + AW'(1);
                end
                if (push_c && !pop_c) begin
                    lap_cnt_q <= lap_cnt_q + CW'(1);
                end else if (pop_c && !push_c) begin
                    lap_cnt_q <= lap_cnt_q - CW'(1);
                end
                if (lap_c && !push_c) begin
                    lap_ovf_q <= 1'b1;
                end
            end
        end
    end

    assign bus.TIME      = time_q;
    assign bus.RUNNING   = running_q;
    assign bus.DONE      = done_q;
    assign bus.LAP_DATA  = lap_data_q;
    assign bus.LAP_VALID = lap_valid_q;
    assign bus.LAP_COUNT = lap_cnt_q;
    assign bus.LAP_OVF   = lap_ovf_q;
`ifdef STOPWATCH_WRAP_EN
    assign bus.WRAP      = wrap_q;
`else
    assign bus.WRAP      = 1'b0;
`endif

endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed self-checking bench for lap_stopwatch; lap values tracked by an expected-value queue.
module tb_lap_stopwatch;
    localparam int unsigned TICK_DIV   = 4;
    localparam int unsigned SEC_DIGITS = 2;
    localparam int unsigned LAP_DEPTH  = 4;

    logic CLK;
    logic RESET;

    lap_stopwatch_if #(.SEC_DIGITS(SEC_DIGITS), .LAP_DEPTH(LAP_DEPTH)) bus ();

    lap_stopwatch #(
        .TICK_DIV  (TICK_DIV),
        .SEC_DIGITS(SEC_DIGITS),
        .LAP_DEPTH (LAP_DEPTH)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    int          n_pass  = 0;
    int          n_fail  = 0;
    int          n_total = 0;
    logic [15:0] exp_q [$];
    logic        exp_ovf;
    logic [15:0] last_data;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic pulse_ss();
        bus.START_STOP = 1'b1;
        step();
        bus.START_STOP = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.CLEAR = 1'b1;
        step();
        bus.CLEAR = 1'b0;
        exp_q.delete();
        exp_ovf   = 1'b0;
        last_data = 16'h0;
    endtask

    // Leaves the bench one step past the tick edge that produced tgt.
    task automatic wait_time(input logic [15:0] tgt, input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (bus.TIME === tgt) break;
        end
        check($sformatf("reach_%h", tgt), 32'(bus.TIME), 32'(tgt));
    endtask

    task automatic lap_at(input logic [15:0] tgt);
        wait_time(tgt, 200);
        bus.LAP = 1'b1;
        step();
        bus.LAP = 1'b0;
        if (exp_q.size() < int'(LAP_DEPTH)) exp_q.push_back(tgt);
        else exp_ovf = 1'b1;
        check($sformatf("lap_count_%h", tgt), 32'(bus.LAP_COUNT), 32'(exp_q.size()));
        check($sformatf("lap_ovf_%h", tgt), 32'(bus.LAP_OVF), 32'(exp_ovf));
    endtask

    task automatic rd_check(input string tag);
        logic [15:0] e;
        bus.LAP_RD = 1'b1;
        step();
        bus.LAP_RD = 1'b0;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            last_data = e;
            check({tag, "_valid"}, 32'(bus.LAP_VALID), 32'd1);
        end else begin
            check({tag, "_novalid"}, 32'(bus.LAP_VALID), 32'd0);
        end
        check({tag, "_data"}, 32'(bus.LAP_DATA), 32'(last_data));
    endtask

    initial begin
        RESET          = 1'b1;
        bus.ENABLE     = 1'b0;
        bus.START_STOP = 1'b0;
        bus.CLEAR      = 1'b0;
        bus.LAP        = 1'b0;
        bus.LAP_RD     = 1'b0;
        exp_ovf        = 1'b0;
        last_data      = 16'h0;

        step(3);
        RESET = 1'b0;
        step();
        check("rst_time",      32'(bus.TIME),      32'd0);
        check("rst_running",   32'(bus.RUNNING),   32'd0);
        check("rst_done",      32'(bus.DONE),      32'd0);
        check("rst_wrap",      32'(bus.WRAP),      32'd0);
        check("rst_lap_data",  32'(bus.LAP_DATA),  32'd0);
        check("rst_lap_valid", 32'(bus.LAP_VALID), 32'd0);
        check("rst_lap_count", 32'(bus.LAP_COUNT), 32'd0);
        check("rst_lap_ovf",   32'(bus.LAP_OVF),   32'd0);

        // First tick lands exactly TICK_DIV edges after START_STOP is sampled.
        bus.ENABLE = 1'b1;
        pulse_ss();
        check("start_running", 32'(bus.RUNNING), 32'd1);
        check("start_time",    32'(bus.TIME),    32'd0);
        step(3);
        check("pre_first_tick", 32'(bus.TIME), 32'h0000);
        step();
        check("first_tick", 32'(bus.TIME), 32'h0001);
        step(40);
        check("forty_more", 32'(bus.TIME), 32'h0011);

        // Pause with two prescaler counts banked; resume ticks two edges later.
        step(2);
        pulse_ss();
        check("pause_running", 32'(bus.RUNNING), 32'd0);
        check("pause_time",    32'(bus.TIME),    32'h0011);
        step(20);
        check("paused_hold", 32'(bus.TIME), 32'h0011);
        pulse_ss();
        check("resume_running", 32'(bus.RUNNING), 32'd1);
        check("resume_time",    32'(bus.TIME),    32'h0011);
        step();
        check("resume_plus1", 32'(bus.TIME), 32'h0011);
        step();
        check("resume_plus2", 32'(bus.TIME), 32'h0012);

        // Lap FIFO fill with overflow, then drain.
        pulse_clr();
        check("clr_time",    32'(bus.TIME),    32'd0);
        check("clr_running", 32'(bus.RUNNING), 32'd0);
        pulse_ss();
        lap_at(16'h0003);
        lap_at(16'h0007);
        lap_at(16'h0012);
        lap_at(16'h0020);
        lap_at(16'h0031);
        rd_check("rd1");
        rd_check("rd2");
        rd_check("rd3");
        rd_check("rd4");
        rd_check("rd5_empty");
        step();
        check("valid_is_pulse", 32'(bus.LAP_VALID), 32'd0);
        check("drained_count",  32'(bus.LAP_COUNT), 32'd0);

        // Lap captured on a tick edge stores the pre-tick time.
        pulse_clr();
        check("clr2_ovf",   32'(bus.LAP_OVF),   32'd0);
        check("clr2_data",  32'(bus.LAP_DATA),  32'd0);
        check("clr2_count", 32'(bus.LAP_COUNT), 32'd0);
        pulse_ss();
        wait_time(16'h0004, 100);
        step(3);
        bus.LAP = 1'b1;
        step();
        bus.LAP = 1'b0;
        exp_q.push_back(16'h0004);
        check("tick_lap_time", 32'(bus.TIME), 32'h0005);
        rd_check("tick_lap_rd");

        // Push and pop together on a full FIFO.
        lap_at(16'h0006);
        lap_at(16'h0007);
        lap_at(16'h0008);
        lap_at(16'h0009);
        wait_time(16'h0010, 100);
        bus.LAP    = 1'b1;
        bus.LAP_RD = 1'b1;
        step();
        bus.LAP    = 1'b0;
        bus.LAP_RD = 1'b0;
        last_data = exp_q.pop_front();
        exp_q.push_back(16'h0010);
        check("both_count", 32'(bus.LAP_COUNT), 32'd4);
        check("both_ovf",   32'(bus.LAP_OVF),   32'd0);
        check("both_valid", 32'(bus.LAP_VALID), 32'd1);
        check("both_data",  32'(bus.LAP_DATA),  32'(last_data));
        rd_check("both_rd1");
        rd_check("both_rd2");
        rd_check("both_rd3");
        rd_check("both_rd4");

        // CLEAR outranks START_STOP.
        bus.START_STOP = 1'b1;
        bus.CLEAR      = 1'b1;
        step();
        bus.START_STOP = 1'b0;
        bus.CLEAR      = 1'b0;
        exp_q.delete();
        last_data = 16'h0;
        check("ss_clr_running", 32'(bus.RUNNING), 32'd0);
        check("ss_clr_time",    32'(bus.TIME),    32'd0);
        step(8);
        check("ss_clr_idle_time", 32'(bus.TIME), 32'd0);

        // Dropping ENABLE mid-run flushes everything.
        pulse_ss();
        lap_at(16'h0002);
        lap_at(16'h0003);
        bus.ENABLE = 1'b0;
        step();
        check("dis_time",    32'(bus.TIME),      32'd0);
        check("dis_count",   32'(bus.LAP_COUNT), 32'd0);
        check("dis_running", 32'(bus.RUNNING),   32'd0);
        bus.ENABLE = 1'b1;
        exp_q.delete();
        exp_ovf = 1'b0;

        // Asynchronous reset between clock edges.
        pulse_ss();
        lap_at(16'h0004);
        wait_time(16'h0005, 100);
        step();
        #2;
        RESET = 1'b1;
        #1;
        check("areset_time",    32'(bus.TIME),      32'd0);
        check("areset_running", 32'(bus.RUNNING),   32'd0);
        check("areset_count",   32'(bus.LAP_COUNT), 32'd0);
        check("areset_done",    32'(bus.DONE),      32'd0);
        check("areset_wrap",    32'(bus.WRAP),      32'd0);
        check("areset_valid",   32'(bus.LAP_VALID), 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        exp_q.delete();
        step(2);
        check("post_reset_idle", 32'(bus.RUNNING), 32'd0);

        // Digit cascade and behaviour at the maximum value.
        pulse_ss();
        wait_time(16'h0999, 5000);
        step(3);
        check("pre_carry", 32'(bus.TIME), 32'h0999);
        step();
        check("carry_1000", 32'(bus.TIME), 32'h1000);
        wait_time(16'h9999, 40000);
        step(3);
        check("at_max", 32'(bus.TIME), 32'h9999);
        step();
`ifdef STOPWATCH_WRAP_EN
        check("wrap_time",    32'(bus.TIME),    32'h0000);
        check("wrap_pulse",   32'(bus.WRAP),    32'd1);
        check("wrap_running", 32'(bus.RUNNING), 32'd1);
        check("wrap_done",    32'(bus.DONE),    32'd0);
        step();
        check("wrap_pulse_end", 32'(bus.WRAP), 32'd0);
`else
        check("sat_time",    32'(bus.TIME),    32'h9999);
        check("sat_done",    32'(bus.DONE),    32'd1);
        check("sat_running", 32'(bus.RUNNING), 32'd0);
        check("sat_wrap",    32'(bus.WRAP),    32'd0);
        pulse_ss();
        check("sat_ss_done",    32'(bus.DONE),    32'd1);
        check("sat_ss_running", 32'(bus.RUNNING), 32'd0);
        step(8);
        check("sat_hold", 32'(bus.TIME), 32'h9999);
        pulse_clr();
        check("sat_clr_done", 32'(bus.DONE), 32'd0);
        check("sat_clr_time", 32'(bus.TIME), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
